uart_tx: RTL and testbench

UART transmitter, the counterpart of the UART receive path. It accepts a parallel byte with a single-cycle valid, then serialises it on o_tx as one frame: start bit, LSB-first data, optional parity, one stop bit. Each bit is held for PRESCALE i_clk cycles, so TX and RX share the same oversampled clock. Control FSM, serializer, parity generator and output mux are all inside this block; o_tx is registered and glitch-free.

---
 rtl/uart_tx.sv | 138 +++++++++++++
 tb/tb_uart_tx.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// UART transmitter: start bit, LSB-first data, optional even/odd parity, one stop bit.
// Every bit is held for PRESCALE clocks; o_tx and o_busy come straight from flops.
module uart_tx #(
   parameter int PRESCALE   = 8,
   parameter int BYTE_WIDTH = 8
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic [BYTE_WIDTH-1:0] i_data,
   input  logic                  i_data_valid,
   input  logic                  i_parity_enable,
   input  logic                  i_parity_type,
   output logic                  o_tx,
   output logic                  o_busy
);

   localparam int CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam int BIT_W = (BYTE_WIDTH > 1) ? $clog2(BYTE_WIDTH) : 1;
   localparam logic [CNT_W-1:0] EDGE_LAST = CNT_W'(PRESCALE - 1);
   localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(BYTE_WIDTH - 1);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } state_t;

   state_t                r_state,    w_state_nxt;
   logic [CNT_W-1:0]      r_edge_cnt, w_edge_cnt_nxt;
   logic [BIT_W-1:0]      r_bit_cnt,  w_bit_cnt_nxt;
   logic [BYTE_WIDTH-1:0] r_shift,    w_shift_nxt;
   logic                  r_par_en,   w_par_en_nxt;
   logic                  r_parity,   w_parity_nxt;
   logic                  r_tx,       w_tx_nxt;
   logic                  r_busy,     w_busy_nxt;
   logic                  w_bit_end;

   assign w_bit_end = (r_edge_cnt == EDGE_LAST);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state    <= IDLE;
         r_edge_cnt <= '0;
         r_bit_cnt  <= '0;
         r_shift    <= '0;
         r_par_en   <= 1'b0;
         r_parity   <= 1'b0;
         r_tx       <= 1'b1;
         r_busy     <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_edge_cnt <= w_edge_cnt_nxt;
         r_bit_cnt  <= w_bit_cnt_nxt;
         r_shift    <= w_shift_nxt;
         r_par_en   <= w_par_en_nxt;
         r_parity   <= w_parity_nxt;
         r_tx       <= w_tx_nxt;
         r_busy     <= w_busy_nxt;
      end
   end

   always_comb begin
      w_state_nxt    = r_state;
      w_edge_cnt_nxt = '0;
      w_bit_cnt_nxt  = r_bit_cnt;
      w_shift_nxt    = r_shift;
      w_par_en_nxt   = r_par_en;
      w_parity_nxt   = r_parity;
      w_tx_nxt       = r_tx;
      w_busy_nxt     = r_busy;

      // The edge counter free-runs within a bit and wraps on the bit boundary.
      if (r_state != IDLE && !w_bit_end)
         w_edge_cnt_nxt = r_edge_cnt + 1'b1;

      case (r_state)
         IDLE: begin
            w_tx_nxt   = 1'b1;
            w_busy_nxt = 1'b0;
            if (i_data_valid) begin
               w_state_nxt   = START;
               w_shift_nxt   = i_data;
               w_par_en_nxt  = i_parity_enable;
               w_parity_nxt  = (^i_data) ^ i_parity_type;
               w_bit_cnt_nxt = '0;
               w_tx_nxt      = 1'b0;
               w_busy_nxt    = 1'b1;
            end
         end
         START: begin
            if (w_bit_end) begin
               w_state_nxt   = DATA;
               w_tx_nxt      = r_shift[0];
               w_shift_nxt   = r_shift >> 1;
               w_bit_cnt_nxt = '0;
            end
         end
         DATA: begin
            if (w_bit_end) begin
               if (r_bit_cnt == BIT_LAST) begin
                  w_state_nxt = r_par_en ? PARITY : STOP;
                  w_tx_nxt    = r_par_en ? r_parity : 1'b1;
               end else begin
                  w_bit_cnt_nxt = r_bit_cnt + 1'b1;
                  w_tx_nxt      = r_shift[0];
                  w_shift_nxt   = r_shift >> 1;
               end
            end
         end
         PARITY: begin
            if (w_bit_end) begin
               w_state_nxt = STOP;
               w_tx_nxt    = 1'b1;
            end
         end
         STOP: begin
            if (w_bit_end) begin
               w_state_nxt = IDLE;
               w_tx_nxt    = 1'b1;
               w_busy_nxt  = 1'b0;
            end
         end
         default: begin
            w_state_nxt    = IDLE;
            w_edge_cnt_nxt = '0;
            w_bit_cnt_nxt  = '0;
            w_tx_nxt       = 1'b1;
            w_busy_nxt     = 1'b0;
         end
      endcase
   end

   assign o_tx   = r_tx;
   assign o_busy = r_busy;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: directed frames are queued as expectations; a monitor decodes the
// serial line cycle by cycle, including a loopback receiver sampling mid-bit.
module tb_uart_tx;

   localparam int PS = 8;

   logic       clk;
   logic       rst_n;
   logic [7:0] data;
   logic       valid;
   logic       pen;
   logic       ptype;
   logic       tx;
   logic       busy;

   typedef struct {
      logic [7:0] data;
      logic       pen;
      logic       pbit;
      int         gap;
      logic       abort;
   } exp_t;

   exp_t q[$];
   int   total;
   int   bad;
   int   frames_done;

   uart_tx #(.PRESCALE(PS), .BYTE_WIDTH(8)) dut (
      .i_clk           (clk),
      .i_rst_n         (rst_n),
      .i_data          (data),
      .i_data_valid    (valid),
      .i_parity_enable (pen),
      .i_parity_type   (ptype),
      .o_tx            (tx),
      .o_busy          (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int req);
      total++;
      if (act != req) begin
         bad++;
         $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
      end
   endtask

   function automatic logic bit_at(input exp_t e, input int pos);
      if (pos == 0) return 1'b0;
      if (pos <= 8) return e.data[pos-1];
      if (pos == 9 && e.pen) return e.pbit;
      return 1'b1;
   endfunction

   // Monitor: one expectation is consumed per frame seen on o_busy.
   initial begin : monitor
      exp_t       e;
      int         idle;
      int         len;
      int         terr;
      int         berr;
      int         first_bad;
      logic [7:0] rx;
      logic       aborted;
      idle = 0;
      forever begin
         @(negedge clk);
         if (!rst_n || !busy) begin
            idle++;
            continue;
         end
         if (q.size() == 0) begin
            chk("unexpected_frame", 1, 0);
            while (busy && rst_n) @(negedge clk);
            idle = 0;
            continue;
         end
         e = q.pop_front();
         if (e.gap >= 0) chk("idle_gap", idle, e.gap);
         len       = (10 + int'(e.pen)) * PS;
         terr      = 0;
         berr      = 0;
         first_bad = -1;
         aborted   = 1'b0;
         rx        = 8'h00;
         for (int i = 0; i < len; i++) begin
            if (i > 0) @(negedge clk);
            if (!rst_n) begin
               aborted = 1'b1;
               break;
            end
            if (tx !== bit_at(e, i / PS)) begin
               if (terr == 0) first_bad = i;
               terr++;
            end
            if (busy !== 1'b1) berr++;
            if ((i % PS) == PS / 2 && (i / PS) >= 1 && (i / PS) <= 8) rx[(i / PS) - 1] = tx;
         end
         chk("frame_aborted", int'(aborted), int'(e.abort));
         if (terr != 0) $display("note: first bad tx sample at frame cycle %0d, data 0x%02h", first_bad, e.data);
         chk("tx_bit_errors", terr, 0);
         chk("busy_low_in_frame", berr, 0);
         if (!aborted) begin
            chk("rx_loopback_byte", int'(rx), int'(e.data));
            @(negedge clk);
            chk("post_frame_busy_tx", int'({busy, tx}), 1);
            idle = 1;
         end else begin
            idle = 0;
         end
         frames_done++;
      end
   end

   task automatic send(input logic [7:0] d, input logic pe, input logic pt, input logic pb,
                       input int gap, input logic ab);
      exp_t e;
      @(negedge clk);
      data  = d;
      pen   = pe;
      ptype = pt;
      valid = 1'b1;
      e.data = d; e.pen = pe; e.pbit = pb; e.gap = gap; e.abort = ab;
      q.push_back(e);
      @(posedge clk);
      #1;
      valid = 1'b0;
      chk("accept_busy", int'(busy), 1);
      chk("accept_start_bit", int'(tx), 0);
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (busy !== 1'b0 && n < 300) begin
         @(negedge clk);
         n++;
      end
      chk("wait_idle_timeout", int'(busy), 0);
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog timeout actual=running required=finished");
      bad++;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin : stimulus
      int errs;
      int n;
      total = 0;
      bad = 0;
      frames_done = 0;

      // Reset with random inputs
      rst_n = 1'b0;
      data  = 8'($urandom);
      valid = 1'($urandom);
      pen   = 1'($urandom);
      ptype = 1'($urandom);
      repeat (3) @(negedge clk);
      chk("reset_tx", int'(tx), 1);
      chk("reset_busy", int'(busy), 0);
      valid = 1'b0;
      rst_n = 1'b1;
      errs  = 0;
      repeat (20) begin
         @(negedge clk);
         if (tx !== 1'b1 || busy !== 1'b0) errs++;
      end
      chk("idle_after_reset", errs, 0);

      // Parity off, even, odd; 0xA5 has four ones, 0x07 has three
      send(8'hA5, 1'b0, 1'b0, 1'b0, -1, 1'b0); wait_idle();
      send(8'hA5, 1'b1, 1'b0, 1'b0, -1, 1'b0); wait_idle();
      send(8'hA5, 1'b1, 1'b1, 1'b1, -1, 1'b0); wait_idle();
      send(8'h07, 1'b1, 1'b0, 1'b1, -1, 1'b0); wait_idle();

      // Valid pulsed mid-frame must be ignored
      send(8'h3C, 1'b0, 1'b0, 1'b0, -1, 1'b0);
      repeat (20) @(negedge clk);
      data  = 8'hFF;
      pen   = 1'b1;
      ptype = 1'b1;
      valid = 1'b1;
      @(negedge clk);
      valid = 1'b0;
      wait_idle();
      errs = 0;
      repeat (30) begin
         @(negedge clk);
         if (busy !== 1'b0 || tx !== 1'b1) errs++;
      end
      chk("no_second_frame", errs, 0);

      // Back-to-back with valid held high
      send(8'h55, 1'b0, 1'b0, 1'b0, -1, 1'b0);
      valid = 1'b1;
      data  = 8'hAA;
      begin
         exp_t e2;
         e2.data = 8'hAA; e2.pen = 1'b0; e2.pbit = 1'b0; e2.gap = 1; e2.abort = 1'b0;
         q.push_back(e2);
      end
      n = 0;
      while (busy === 1'b1 && n < 200) begin @(negedge clk); n++; end
      n = 0;
      while (busy !== 1'b1 && n < 5) begin @(negedge clk); n++; end
      chk("b2b_second_start", int'(busy), 1);
      valid = 1'b0;
      wait_idle();

      // Reset in the middle of a frame
      send(8'hC3, 1'b0, 1'b0, 1'b0, -1, 1'b1);
      repeat (29) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_reset_tx", int'(tx), 1);
      chk("async_reset_busy", int'(busy), 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      send(8'h81, 1'b0, 1'b0, 1'b0, -1, 1'b0);
      wait_idle();

      repeat (5) @(negedge clk);
      chk("queue_drained", q.size(), 0);
      chk("frames_seen", frames_done, 9);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
